// File: rtl/frame_sync_regs.sv
// frame_sync_regs
//   Double-buffered Avalon-MM register bank in front of the VGA renderer.
//   Software fills a shadow bank at any time and requests a commit. The
//   shadow bank is copied into the active bank only during vertical blanking.
//   Each completed commit advances frame_count and raises irq.
//
// Bus handshake: Avalon-MM slave without waitrequest. An access is a cycle
//   with chipselect high and write or read high. Every access completes in
//   that cycle. Read data appears on readdata one cycle later and holds until
//   the next read.
//
// Ports:
//   clk, reset     system clock; asynchronous active-high reset
//   chipselect     Avalon select
//   write, read    Avalon strobes
//   address        word address: data slots, then COMMIT, then STATUS
//   writedata      write data byte
//   readdata       registered read data
//   vcount         current line from the VGA timing generator
//   regs_active    flattened active bank, byte i at [8i+7:8i]
//   frame_count    completed commits, mod 256
//   irq            level interrupt, set on commit completion
module frame_sync_regs #(
    parameter int NUM_REGS = 64,
    parameter int VACTIVE  = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic                      read,
    input  logic [5:0]                address,
    input  logic [7:0]                writedata,
    output logic [7:0]                readdata,
    input  logic [9:0]                vcount,
    output logic [(NUM_REGS-2)*8-1:0] regs_active,
    output logic [7:0]                frame_count,
    output logic                      irq
);
    localparam int         NUM_DATA    = NUM_REGS - 2;
    localparam logic [5:0] COMMIT_ADDR = 6'(NUM_REGS - 2);
    localparam logic [5:0] STATUS_ADDR = 6'(NUM_REGS - 1);
    localparam logic [5:0] LAST_IDX    = 6'(NUM_REGS - 3);
    localparam logic [9:0] VBLANK_LINE = 10'(VACTIVE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [7:0] shadow [NUM_DATA];
    logic [7:0] active [NUM_DATA];
    logic [5:0] idx;
    logic       pend_next;
    logic [9:0] vcount_d;

    logic bus_wr, data_write, commit_req, status_clr, vblank_start;

    assign bus_wr       = chipselect & write;
    assign data_write   = bus_wr & (address < COMMIT_ADDR);
    assign commit_req   = bus_wr & (address == COMMIT_ADDR);
    assign status_clr   = bus_wr & (address == STATUS_ADDR) & writedata[1];
    // Only the first cycle at the blanking line counts, however long vcount
    // dwells there.
    assign vblank_start = (vcount == VBLANK_LINE) & (vcount_d != VBLANK_LINE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vcount_d <= '0;
        else       vcount_d <= vcount;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (commit_req) state_n = PENDING;
            PENDING: if (vblank_start) state_n = COPY;
            COPY:    if (idx == LAST_IDX) state_n = DONE;
            DONE:    state_n = (pend_next | commit_req) ? PENDING : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            pend_next   <= 1'b0;
            frame_count <= '0;
            irq         <= 1'b0;
        end else begin
            // idx rests at 0 outside COPY so a copy always starts at slot 0.
            if (state == COPY) idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
            else               idx <= 6'd0;

            if (state == DONE)                    pend_next <= 1'b0;
            else if (state == COPY && commit_req) pend_next <= 1'b1;

            if (state == DONE) frame_count <= frame_count + 8'd1;

            // Completion beats a same-cycle software clear.
            if (state == DONE)   irq <= 1'b1;
            else if (status_clr) irq <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DATA; i++) shadow[i] <= '0;
        end else if (data_write) begin
            shadow[address] <= writedata;
        end
    end

    // The copy reads shadow before this cycle's write, so a write that hits
    // the slot being copied waits for the next commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DATA; i++) active[i] <= '0;
        end else if (state == COPY) begin
            active[idx] <= shadow[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (chipselect & read) begin
            if (address < COMMIT_ADDR)       readdata <= shadow[address];
            else if (address == COMMIT_ADDR) readdata <= frame_count;
            else                             readdata <= {5'b0, pend_next, irq, state != IDLE};
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DATA; g++) begin : g_flat
            assign regs_active[8*g +: 8] = active[g];
        end
    endgenerate

endmodule

// File: tb/tb_frame_sync_regs.sv
// tb_frame_sync_regs
//   Directed scenarios followed by randomized bus traffic and a free-running
//   fake vcount, all checked every cycle against a behavioural model that
//   works from commit timing (copy of slot i at edge V+1+i, completion at
//   V+63) rather than from a state machine.
module tb_frame_sync_regs;
    localparam int NUM_REGS = 64;
    localparam int ND       = NUM_REGS - 2;
    localparam int AW       = ND * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          chipselect;
    logic          write;
    logic          read;
    logic [5:0]    address;
    logic [7:0]    writedata;
    logic [7:0]    readdata;
    logic [9:0]    vcount;
    logic [AW-1:0] regs_active;
    logic [7:0]    frame_count;
    logic          irq;

    frame_sync_regs #(.NUM_REGS(NUM_REGS), .VACTIVE(480)) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .vcount      (vcount),
        .regs_active (regs_active),
        .frame_count (frame_count),
        .irq         (irq)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sh_m [ND];
    logic [7:0] ac_m [ND];
    logic [7:0] fc_m, rd_m;
    logic       irq_m, pend_m, wait_m;
    int         copy_v;        // cycle in which the copy's vblank was seen, -1 if none
    int         cyc;           // number of rising edges so far
    logic [9:0] vprev;
    logic [7:0] exp_q [$];     // expected read returns

    function automatic logic [AW-1:0] pack_active();
        logic [AW-1:0] v;
        v = '0;
        for (int i = 0; i < ND; i++) v[8*i +: 8] = ac_m[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            sh_m[i] = 8'h00;
            ac_m[i] = 8'h00;
        end
        fc_m   = 8'h00;
        rd_m   = 8'h00;
        irq_m  = 1'b0;
        pend_m = 1'b0;
        wait_m = 1'b0;
        copy_v = -1;
        vprev  = 10'd0;
        exp_q.delete();
    endtask

    // Apply the effect of the cycle that ends at the next rising edge.
    task automatic model_cycle();
        int c;
        bit vb, cmt, clr, in_copy, in_done, busy;
        c       = cyc + 1;
        vb      = (vcount == 10'd480) && (vprev != 10'd480);
        cmt     = chipselect && write && (address == 6'd62);
        clr     = chipselect && write && (address == 6'd63) && writedata[1];
        in_copy = (copy_v >= 0) && (c >= copy_v + 1) && (c <= copy_v + 62);
        in_done = (copy_v >= 0) && (c == copy_v + 63);
        busy    = wait_m || (copy_v >= 0);

        if (chipselect && read) begin
            if (address < 6'd62)       rd_m = sh_m[address];
            else if (address == 6'd62) rd_m = fc_m;
            else                       rd_m = {5'b0, pend_m, irq_m, busy};
            exp_q.push_back(rd_m);
        end

        if (in_copy) ac_m[c - copy_v - 1] = sh_m[c - copy_v - 1];
        if (chipselect && write && address < 6'd62) sh_m[address] = writedata;

        if (in_done) begin
            fc_m   = fc_m + 8'd1;
            irq_m  = 1'b1;
            copy_v = -1;
            wait_m = pend_m || cmt;
            pend_m = 1'b0;
        end else begin
            if (clr) irq_m = 1'b0;
            if (in_copy && cmt) pend_m = 1'b1;
            if (wait_m && vb) begin
                copy_v = c;
                wait_m = 1'b0;
            end else if (!busy && cmt) begin
                wait_m = 1'b1;
            end
        end
        vprev = vcount;
    endtask

    task automatic check_outputs();
        check("readdata", readdata, rd_m);
        check("frame_count", frame_count, fc_m);
        check("irq", irq, irq_m);
        check("regs_active", regs_active, pack_active());
    endtask

    // ---------------- drivers ----------------
    task automatic bus_idle();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 6'd0;
        writedata  = 8'h00;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (exp_q.size() > 0) check("read_return", readdata, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        bus_idle();
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = a;
        writedata  = d;
        step();
        bus_idle();
    endtask

    task automatic bus_read(input logic [5:0] a);
        chipselect = 1'b1;
        write      = 1'b0;
        read       = 1'b1;
        address    = a;
        writedata  = 8'h00;
        step();
        bus_idle();
    endtask

    // Called at posedge+1; reset asserts between edges.
    task automatic do_reset();
        bus_idle();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        reset = 1'b0;
    endtask

    task automatic run_frame();
        for (int l = 470; l < 480; l++) begin
            vcount = 10'(l);
            idle(1);
        end
        vcount = 10'd480;
        idle(70);
        vcount = 10'd0;
        idle(5);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int line;
        int r;
        cyc    = 0;
        vcount = 10'd0;
        bus_idle();
        #1;
        do_reset();

        // Reset state.
        bus_read(6'd5);
        check("rd_addr5_reset", readdata, 8'h00);
        bus_read(6'd63);
        check("rd_status_reset", readdata, 8'h00);
        check("irq_reset", irq, 1'b0);
        check("active_reset", regs_active, '0);

        // Shadow writes without commit never reach the active bank.
        bus_write(6'd3, 8'hC8);
        bus_write(6'd5, 8'hF0);
        run_frame();
        run_frame();
        check("no_commit_a3", regs_active[31:24], 8'h00);
        check("no_commit_a5", regs_active[47:40], 8'h00);
        check("no_commit_fc", frame_count, 8'h00);

        // Single commit: slot 3 lands at V+4, completion at V+63.
        vcount = 10'd100;
        bus_write(6'd3, 8'hC8);
        bus_write(6'd62, 8'h00);
        vcount = 10'd479;
        idle(1);
        vcount = 10'd480;
        idle(1);                      // edge V
        idle(3);
        check("a3_before", regs_active[31:24], 8'h00);
        idle(1);                      // edge V+4
        check("a3_copied", regs_active[31:24], 8'hC8);
        idle(59);                     // edge V+63
        check("fc_after_commit", frame_count, 8'd1);
        check("irq_after_commit", irq, 1'b1);
        bus_read(6'd63);
        check("status_idle_irq", readdata, 8'h02);

        // Write during copy plus a second commit queued as pend_next.
        vcount = 10'd0;
        idle(1);
        bus_write(6'd62, 8'h00);
        vcount = 10'd480;
        idle(1);                      // edge V
        idle(10);                     // V+11 has idx 10
        bus_write(6'd0, 8'h11);
        bus_write(6'd62, 8'h00);
        bus_read(6'd63);
        check("status_pend", readdata, 8'h07);
        idle(60);                     // past V+63, now waiting for next vblank
        check("fc_second", frame_count, 8'd2);
        check("a0_not_yet", regs_active[7:0], 8'h00);
        vcount = 10'd0;
        idle(1);
        vcount = 10'd480;
        idle(1);
        idle(63);
        check("a0_copied", regs_active[7:0], 8'h11);
        check("fc_third", frame_count, 8'd3);

        // Clear coinciding with DONE loses; a later clear wins.
        bus_write(6'd63, 8'h02);
        check("irq_cleared", irq, 1'b0);
        vcount = 10'd0;
        bus_write(6'd62, 8'h00);
        vcount = 10'd480;
        idle(1);                      // edge V
        idle(62);
        bus_write(6'd63, 8'h02);      // cycle V+63 is DONE
        check("irq_set_wins", irq, 1'b1);
        check("fc_fourth", frame_count, 8'd4);
        bus_write(6'd63, 8'h02);
        check("irq_clear_after", irq, 1'b0);

        // Reset in the middle of a copy.
        vcount = 10'd0;
        bus_write(6'd7, 8'h5A);
        bus_write(6'd62, 8'h00);
        vcount = 10'd480;
        idle(1);                      // edge V
        idle(30);
        do_reset();
        check("active_abort", regs_active, '0);
        check("fc_abort", frame_count, 8'h00);
        vcount = 10'd0;
        idle(1);
        run_frame();
        check("fc_no_copy", frame_count, 8'h00);
        check("irq_no_copy", irq, 1'b0);
        check("active_no_copy", regs_active, '0);

        // Randomized traffic with a wandering vcount.
        line = 400;
        for (int n = 0; n < 3000; n++) begin
            bus_idle();
            r = $urandom_range(0, 99);
            if (r < 30) begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = 6'($urandom_range(0, 61));
                writedata  = 8'($urandom_range(0, 255));
            end else if (r < 35) begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = 6'd62;
                writedata  = 8'($urandom_range(0, 255));
            end else if (r < 38) begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = 6'd63;
                writedata  = 8'($urandom_range(0, 255));
            end else if (r < 60) begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = 6'($urandom_range(0, 63));
            end else if (r < 63) begin
                write      = 1'b1;    // strobe without select is ignored
                address    = 6'($urandom_range(0, 63));
                writedata  = 8'hFF;
            end
            vcount = 10'(line);
            step();
            if ($urandom_range(0, 9) < 7) line = (line == 499) ? 400 : line + 1;
        end
        bus_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
